// File: rtl/fp_mul_pipelined.sv
// fp_mul_pipelined
//   Three-stage pipelined floating-point multiplier for an IEEE-754-style
//   {sign, exponent, fraction} format with configurable field widths.
//   Stage 1 unpacks and classifies both operands and resolves every special
//   case (NaN, infinity, zero). Stage 2 forms the full significand product
//   and the unbiased exponent sum. Stage 3 normalises, rounds to nearest
//   ties-to-even, detects overflow/underflow and drives the output registers.
//   Subnormal inputs are treated as signed zero. Results that fall below the
//   normal range are flushed to signed zero.
//
//   A single global stall is used: when the output holds a result that the
//   consumer has not taken, every stage freezes. Bubbles travel through the
//   pipeline like normal entries but never raise out_valid.
//
// Ports
//   clk        sole clock, rising edge
//   reset_n    asynchronous active-low reset
//   in_valid   operand pair a/b is present
//   in_ready   pipeline accepts operands this cycle
//   a, b       operands, W = 1+EXP_W+MAN_W bits
//   out_valid  result/flags are valid
//   out_ready  consumer accepts the result this cycle
//   result     product, W bits
//   flags      {invalid, overflow, underflow, inexact}, aligned with result

module fp_mul_pipelined #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);

  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int SIG_W  = MAN_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int E_W    = EXP_W + 2;

  localparam logic signed [E_W-1:0] BIAS   = E_W'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [E_W-1:0] E_MAX  = E_W'((1 << EXP_W) - 1);
  localparam logic signed [E_W-1:0] E_ZERO = '0;
  localparam logic [W-1:0]          QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Global advance: the whole pipeline moves only when the output slot is
  // empty or being drained this cycle.
  logic adv;

  // Stage 1 registers (unpack / classify)
  logic                s1_valid_d,      s1_valid_q;
  logic                s1_sign_d,       s1_sign_q;
  logic [EXP_W-1:0]    s1_exp_a_d,      s1_exp_a_q;
  logic [EXP_W-1:0]    s1_exp_b_d,      s1_exp_b_q;
  logic [SIG_W-1:0]    s1_sig_a_d,      s1_sig_a_q;
  logic [SIG_W-1:0]    s1_sig_b_d,      s1_sig_b_q;
  logic                s1_special_d,    s1_special_q;
  logic [W-1:0]        s1_spec_res_d,   s1_spec_res_q;
  logic [3:0]          s1_spec_flags_d, s1_spec_flags_q;

  // Stage 2 registers (multiply / exponent add)
  logic                s2_valid_d,      s2_valid_q;
  logic                s2_sign_d,       s2_sign_q;
  logic [PROD_W-1:0]   s2_prod_d,       s2_prod_q;
  logic signed [E_W-1:0] s2_exp_d,      s2_exp_q;
  logic                s2_special_d,    s2_special_q;
  logic [W-1:0]        s2_spec_res_d,   s2_spec_res_q;
  logic [3:0]          s2_spec_flags_d, s2_spec_flags_q;

  // Stage 3 / output registers (normalise / round / pack)
  logic                out_valid_d,     out_valid_q;
  logic [W-1:0]        result_d,        result_q;
  logic [3:0]          flags_d,         flags_q;

  // Operand fields
  logic                sign_a, sign_b;
  logic [EXP_W-1:0]    exp_a, exp_b;
  logic [MAN_W-1:0]    frac_a, frac_b;
  logic                a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  // Stage 3 intermediates
  logic                top;
  logic [MAN_W-1:0]    frac_raw;
  logic                guard_bit, round_bit, sticky_bit;
  logic                round_up, carry, inexact;
  logic [MAN_W-1:0]    frac_rnd;
  logic signed [E_W-1:0] exp_fin;

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

  assign sign_a = a[W-1];
  assign sign_b = b[W-1];
  assign exp_a  = a[W-2:MAN_W];
  assign exp_b  = b[W-2:MAN_W];
  assign frac_a = a[MAN_W-1:0];
  assign frac_b = b[MAN_W-1:0];

  // Classification. Exponent zero covers both true zero and subnormals,
  // which are deliberately treated as zero.
  assign a_nan  = (&exp_a) && (frac_a != '0);
  assign b_nan  = (&exp_b) && (frac_b != '0);
  assign a_inf  = (&exp_a) && (frac_a == '0);
  assign b_inf  = (&exp_b) && (frac_b == '0);
  assign a_zero = (exp_a == '0);
  assign b_zero = (exp_b == '0);

  // Stage 1: unpack and resolve special operands. Priority is NaN first,
  // then infinity x zero, then infinity, then zero; anything left is a pair
  // of normal numbers that goes through the arithmetic path.
  always_comb begin
    s1_valid_d      = in_valid;
    s1_sign_d       = sign_a ^ sign_b;
    s1_exp_a_d      = exp_a;
    s1_exp_b_d      = exp_b;
    s1_sig_a_d      = {1'b1, frac_a};
    s1_sig_b_d      = {1'b1, frac_b};
    s1_special_d    = 1'b1;
    s1_spec_res_d   = '0;
    s1_spec_flags_d = '0;
    if (a_nan || b_nan) begin
      // Invalid only when a NaN input is signalling (fraction MSB clear).
      s1_spec_res_d   = QNAN;
      s1_spec_flags_d = {(a_nan && !frac_a[MAN_W-1]) || (b_nan && !frac_b[MAN_W-1]), 3'b000};
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      s1_spec_res_d   = QNAN;
      s1_spec_flags_d = 4'b1000;
    end else if (a_inf || b_inf) begin
      s1_spec_res_d   = {sign_a ^ sign_b, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      s1_spec_res_d   = {sign_a ^ sign_b, {(W-1){1'b0}}};
    end else begin
      s1_special_d    = 1'b0;
    end
  end

  // Stage 2: full-width significand product and unbiased exponent sum.
  // The exponent is kept two bits wider than the field so both overflow
  // and underflow remain visible after normalisation and rounding.
  always_comb begin
    s2_valid_d      = s1_valid_q;
    s2_sign_d       = s1_sign_q;
    s2_prod_d       = PROD_W'(s1_sig_a_q) * PROD_W'(s1_sig_b_q);
    s2_exp_d        = $signed({2'b00, s1_exp_a_q}) + $signed({2'b00, s1_exp_b_q}) - BIAS;
    s2_special_d    = s1_special_q;
    s2_spec_res_d   = s1_spec_res_q;
    s2_spec_flags_d = s1_spec_flags_q;
  end

  // Stage 3 normalisation: the product of two [1,2) significands lies in
  // [1,4), so the leading one is at one of the two top bit positions. The
  // bits below the kept fraction provide guard, round and sticky.
  always_comb begin
    top = s2_prod_q[PROD_W-1];
    if (top) begin
      frac_raw   = s2_prod_q[2*MAN_W -: MAN_W];
      guard_bit  = s2_prod_q[MAN_W];
      round_bit  = s2_prod_q[MAN_W-1];
      sticky_bit = |s2_prod_q[MAN_W-2:0];
    end else begin
      frac_raw   = s2_prod_q[2*MAN_W-1 -: MAN_W];
      guard_bit  = s2_prod_q[MAN_W-1];
      round_bit  = s2_prod_q[MAN_W-2];
      sticky_bit = |s2_prod_q[MAN_W-3:0];
    end
    // Ties-to-even: on an exact half, round up only if the kept LSB is odd.
    round_up = guard_bit && (round_bit || sticky_bit || frac_raw[0]);
    inexact  = guard_bit || round_bit || sticky_bit;
    // Rounding an all-ones fraction wraps it to zero and carries into the
    // hidden bit, which is the same as 1.0 at the next exponent.
    frac_rnd = frac_raw + MAN_W'(round_up);
    carry    = round_up && (&frac_raw);
    exp_fin  = s2_exp_q + E_W'(top) + E_W'(carry);
  end

  // Stage 3 packing: special cases bypass the arithmetic; otherwise range
  // checks are done on the final exponent after rounding.
  always_comb begin
    out_valid_d = s2_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    if (s2_valid_q) begin
      if (s2_special_q) begin
        result_d = s2_spec_res_q;
        flags_d  = s2_spec_flags_q;
      end else if (exp_fin >= E_MAX) begin
        result_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        flags_d  = 4'b0101;
      end else if (exp_fin <= E_ZERO) begin
        result_d = {s2_sign_q, {(W-1){1'b0}}};
        flags_d  = 4'b0011;
      end else begin
        result_d = {s2_sign_q, exp_fin[EXP_W-1:0], frac_rnd};
        flags_d  = {3'b000, inexact};
      end
    end
  end

  // Control state and the visible outputs are reset; a reset drops any
  // operation in flight by clearing every valid bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else if (adv) begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  // Datapath registers carry no reset; their contents only matter when the
  // matching valid bit is set.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign_q       <= s1_sign_d;
      s1_exp_a_q      <= s1_exp_a_d;
      s1_exp_b_q      <= s1_exp_b_d;
      s1_sig_a_q      <= s1_sig_a_d;
      s1_sig_b_q      <= s1_sig_b_d;
      s1_special_q    <= s1_special_d;
      s1_spec_res_q   <= s1_spec_res_d;
      s1_spec_flags_q <= s1_spec_flags_d;
      s2_sign_q       <= s2_sign_d;
      s2_prod_q       <= s2_prod_d;
      s2_exp_q        <= s2_exp_d;
      s2_special_q    <= s2_special_d;
      s2_spec_res_q   <= s2_spec_res_d;
      s2_spec_flags_q <= s2_spec_flags_d;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipelined.sv
// tb_fp_mul_pipelined
//   Scoreboard bench for fp_mul_pipelined at FP32 defaults. Each accepted
//   operand pair pushes its expected result/flags into a queue; a monitor
//   pops and compares whenever a result transfers out. Expected values come
//   either from fixed reference constants or from an integer model of the
//   multiply built from value-level arithmetic (exact product, quotient and
//   remainder rounding).

module tb_fp_mul_pipelined;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [3:0]  flags;

  fp_mul_pipelined #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t sb_q[$];
  int   out_cycles[$];

  function automatic void checkOutput(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  // Value-level model: returns {result, flags}.
  function automatic logic [35:0] refMul(logic [31:0] x, logic [31:0] y);
    logic              s;
    logic [7:0]        ex, ey;
    logic [22:0]       fx, fy;
    bit                x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
    longint unsigned   mx, my, p, q, rem, half;
    int                sh, e;
    bit                inx;
    s  = x[31] ^ y[31];
    ex = x[30:23]; ey = y[30:23];
    fx = x[22:0];  fy = y[22:0];
    x_nan  = (ex == 8'hFF) && (fx != 0);
    y_nan  = (ey == 8'hFF) && (fy != 0);
    x_inf  = (ex == 8'hFF) && (fx == 0);
    y_inf  = (ey == 8'hFF) && (fy == 0);
    x_zero = (ex == 0);
    y_zero = (ey == 0);
    if (x_nan || y_nan)
      return {32'h7FC00000, ((x_nan && !fx[22]) || (y_nan && !fy[22])), 3'b000};
    if ((x_inf && y_zero) || (y_inf && x_zero))
      return {32'h7FC00000, 4'b1000};
    if (x_inf || y_inf)
      return {s, 8'hFF, 23'h0, 4'b0000};
    if (x_zero || y_zero)
      return {s, 31'h0, 4'b0000};
    mx = {41'h0, 1'b1, fx};
    my = {41'h0, 1'b1, fy};
    p  = mx * my;
    sh = (p >= (64'd1 << 47)) ? 24 : 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    e    = int'(ex) + int'(ey) - 127 + (sh - 23);
    inx  = (rem != 0);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0, 4'b0101};
    if (e <= 0)   return {s, 31'h0, 4'b0011};
    return {s, e[7:0], q[22:0], 3'b000, inx};
  endfunction

  function automatic logic [31:0] randOperand();
    int          cls;
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    cls = $urandom_range(0, 11);
    s   = 1'($urandom);
    f   = 23'($urandom);
    case (cls)
      0:       e = 8'h00;
      1:       begin e = 8'hFF; f = '0; end
      2:       begin e = 8'hFF; if (f == 0) f = 23'h1; end
      3:       e = 8'($urandom_range(220, 254));
      4:       e = 8'($urandom_range(1, 30));
      5:       begin e = 8'($urandom_range(120, 134)); f = {21'h1FFFFF, 2'($urandom)}; end
      default: e = 8'($urandom_range(90, 164));
    endcase
    return {s, e, f};
  endfunction

  function automatic logic [31:0] randNormal();
    return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  // Called just after a rising edge; returns just after the rising edge on
  // which the pair was accepted, leaving in_valid high for the caller.
  task automatic applyStimulus(input logic [31:0] op_a, input logic [31:0] op_b,
                               input logic [31:0] exp_res, input logic [3:0] exp_flg,
                               input bit chk_lat);
    bit   done;
    int   waited;
    exp_t e;
    done   = 0;
    waited = 0;
    in_valid = 1'b1;
    a = op_a;
    b = op_b;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        e.res = exp_res; e.flg = exp_flg; e.acc_cyc = cyc; e.chk_lat = chk_lat;
        sb_q.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
      waited++;
      if (!done && waited > 500) begin
        checkOutput("accept_timeout", in_ready, 1);
        done = 1;
      end
    end
  endtask

  task automatic applyModel(input logic [31:0] op_a, input logic [31:0] op_b, input bit chk_lat);
    logic [35:0] r;
    r = refMul(op_a, op_b);
    applyStimulus(op_a, op_b, r[35:4], r[3:0], chk_lat);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (sb_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain_timeout", sb_q.size(), 0);
  endtask

  // Monitor: compares each transferred result with the scoreboard head and
  // checks that a held result does not change while the consumer stalls.
  logic [31:0] held_res;
  logic [3:0]  held_flg;
  bit          held = 0;
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        held = 0;
      end else begin
        if (held) begin
          checkOutput("hold_out_valid", out_valid, 1);
          checkOutput("hold_result", result, held_res);
          checkOutput("hold_flags", flags, held_flg);
        end
        if (out_valid && out_ready) begin
          out_cycles.push_back(cyc);
          if (sb_q.size() == 0) begin
            checkOutput("spurious_out_valid", out_valid, 0);
          end else begin
            e = sb_q.pop_front();
            checkOutput("result", result, e.res);
            checkOutput("flags", flags, e.flg);
            if (e.chk_lat) checkOutput("latency", cyc - e.acc_cyc, 3);
          end
        end
        held     = out_valid && !out_ready;
        held_res = result;
        held_flg = flags;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [31:0] x, y;
    logic [35:0] r;
    bit          rnd_done;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_result", result, 0);
    checkOutput("reset_flags", flags, 0);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    #1;
    checkOutput("reset_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Directed reference cases
    $display("[TB] directed cases");
    applyStimulus(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 1);
    applyStimulus(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 1);
    applyStimulus(32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101, 1);
    applyStimulus(32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, 1);
    applyStimulus(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 1);
    applyStimulus(32'h00000000, 32'hFF800000, 32'h7FC00000, 4'b1000, 1);
    applyStimulus(32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000, 1);
    applyStimulus(32'hFFC00000, 32'h3F800000, 32'h7FC00000, 4'b0000, 1);
    applyStimulus(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1);
    applyStimulus(32'h80000000, 32'h40000000, 32'h80000000, 4'b0000, 1);
    applyStimulus(32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 1);
    waitDrain();

    // Back-to-back with consumer always ready
    $display("[TB] back-to-back");
    out_cycles.delete();
    for (int i = 0; i < 8; i++) applyModel(randNormal(), randNormal(), 1);
    waitDrain();
    checkOutput("b2b_count", out_cycles.size(), 8);
    if (out_cycles.size() == 8) checkOutput("b2b_span", out_cycles[7] - out_cycles[0], 7);

    // Consumer stall with four operations offered
    $display("[TB] consumer stall");
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) applyModel(randNormal(), randNormal(), 0);
        in_valid = 1'b0;
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        checkOutput("stall_in_ready", in_ready, 0);
        checkOutput("stall_out_valid", out_valid, 1);
        out_ready = 1'b1;
      end
    join
    waitDrain();

    // Reset with three operations in flight
    $display("[TB] reset in flight");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) applyModel(randNormal(), randNormal(), 0);
    in_valid = 1'b0;
    checkOutput("pre_reset_out_valid", out_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_out_valid", out_valid, 0);
    checkOutput("async_reset_result", result, 0);
    checkOutput("async_reset_flags", flags, 0);
    sb_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    checkOutput("post_reset_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("post_reset_out_valid", out_valid, 0);
    applyStimulus(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 1);
    waitDrain();

    // Randomised traffic with random consumer back-pressure
    $display("[TB] random traffic");
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          x = randOperand();
          y = randOperand();
          r = refMul(x, y);
          applyStimulus(x, y, r[35:4], r[3:0], 0);
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
          end
        end
        in_valid = 1'b0;
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    waitDrain();
    repeat (5) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
